note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Parametrised successor to the fixed 4-channel beat/lookahead logic in the APU top level. It walks a pattern memory between programmable loop bounds at a fixed note rate and emits NUM_CH tone codes per note, with per-channel one-shot overrides that last a programmable number of notes. Lookahead tones go through a small FIFO with a valid/ready handshake, which replaces the old acknowledge-level scheme. It sits between the pattern BRAM (single registered read port) and the tone_gen/wave generators, and runs on the slow audio clock.

Parameters:
NUM_CH, 4, number of tone channels
TONE_W, 4, bits per tone code; code 0 = silent
ADDR_W, 10, pattern memory address width
CLK_HZ, 12_288_000, clk frequency
NOTE_HZ, 1, note rate; PERIOD = CLK_HZ/NOTE_HZ, must be >= 8 (elaboration-time check)
LA_DEPTH, 4, lookahead FIFO depth, power of two
OS_LEN_W, 4, one-shot duration width (in notes)

Ports:
clk  in  1  clock
reset  in  1  async, active-high
enable  in  1  high = run; low = freeze tick counter and FSM, outputs hold
restart  in  1  sync pulse: return to start_addr, flush FIFO, clear one-shots
start_addr  in  ADDR_W  loop start
end_addr  in  ADDR_W  loop end, inclusive
la_offset  in  ADDR_W  lookahead distance in notes
mem_addr  out  ADDR_W  pattern read address
mem_rdata  in  NUM_CH*TONE_W  read data, valid 1 cycle after mem_addr; ch0 in MSBs
os_valid  in  1  one-shot request
os_tones  in  NUM_CH*TONE_W  override tones; 0 in a field = no override for that channel
os_len  in  OS_LEN_W  override duration in notes; 0 treated as 1
os_ready  out  1  high when no one-shot is active
tones  out  NUM_CH*TONE_W  effective tones to tone_gen
note_tick  out  1  1-cycle pulse per note
timestamp  out  ADDR_W  cur_addr - start_addr, modulo 2^ADDR_W
la_valid  out  1  FIFO non-empty
la_tone  out  TONE_W  FIFO head (channel NUM_CH-1 of the lookahead word)
la_ready  in  1  consumer pop; pop occurs when la_valid && la_ready
la_overflow  out  1  sticky; set on a push while full; cleared by reset or restart

Behaviour:
- Reset values: cur_addr=start_addr (sampled), state=FETCH_CUR, tick counter 0, tones=0, note_tick=0, os_ready=1, FIFO empty, la_valid=0, la_overflow=0, mem_addr=0.
- Tick counter counts 0..PERIOD-1 while enable is high. note_tick is asserted in the cycle the counter is at PERIOD-1.
- Loop advance on note_tick: next = (cur_addr >= end_addr) ? start_addr : cur_addr+1. If end_addr <= start_addr, cur_addr stays at start_addr.
- Lookahead address: cur_addr + la_offset, wrapped into [start_addr, end_addr] by subtracting the loop length (end-start+1) once when it is exceeded. la_offset >= loop length is unsupported; the result then only needs to stay inside the loop.
- FSM states: IDLE, FETCH_CUR, FETCH_LA, CAP_LA, PLAY.
  - On a note_tick in PLAY (or IDLE): go to FETCH_CUR.
  - FETCH_CUR: mem_addr = cur_addr.
  - FETCH_LA: mem_addr = la_addr; mem_rdata (current word) is captured into the pattern register.
  - CAP_LA: mem_rdata is the lookahead word. Push its channel NUM_CH-1 field only if the field is non-zero.
  - Then go to PLAY.
  - Timing: tick at cycle T, new tones visible at T+3, pushed la_tone visible at T+4.
- Initial fetch after reset or restart runs without waiting for a tick.
- Effective tones: per channel, tones[ch] = os_active[ch] ? os_tone[ch] : pattern[ch].
- One-shot:
  - Accepted when os_valid && os_ready.
  - Latches the non-zero fields of os_tones and loads remaining = max(os_len,1).
  - Overrides apply from the next cycle.
  - remaining decrements on each note_tick; when it reaches 0, all overrides clear and os_ready=1.
  - Requests while busy are ignored.
- FIFO:
  - Push and pop in the same cycle while full: both succeed.
  - Push while full without a pop: data dropped, la_overflow set.
  - Pop while empty: ignored.
- restart takes priority over everything in its cycle. Effects: cur_addr=start_addr, FIFO flushed, one-shots cleared, tick counter 0, state=FETCH_CUR. Current tones hold until the refetch completes.
- enable low mid-fetch: the FSM pauses in its state. mem_addr holds, so the captured data remains correct on resume.
- Reset mid-operation returns every register to its reset value immediately (async).

Decomposition:
- Package apu_pkg holds:
  - the FSM state enum
  - the SILENT tone constant (0)
  - helper function for channel field slicing
- One sub-module: la_fifo, a parametrised synchronous FIFO (depth, width, full/empty, push-drop flag).

Test Plan:
All scenarios use CLK_HZ=16, NOTE_HZ=1 (PERIOD=16), NUM_CH=4, and memory preloaded with word i = 16'h1110+i.
- Loop wrap: start=2, end=4 → tones sequence 0x1112,0x1113,0x1114,0x1112; timestamp 0,1,2,0; note_tick every 16 cycles.
- Latency: note_tick at cycle T → mem_addr=cur at T+1, la_addr at T+2; tones change at T+3; la_valid rises at T+4.
- Lookahead: start=0, end=7, la_offset=3, la_ready=1 → at cur 6, la_tone = low nibble of word 1 (=1). Word with zero nibble is not pushed.
- Overflow: la_ready=0, LA_DEPTH=4, 5 non-zero pushes → la_valid=1, 4 entries popped in order, la_overflow=1; restart clears it.
- One-shot: os_tones=16'h0F00, os_len=2 → ch1 reads 0xF for exactly 2 notes while other channels follow the pattern; os_ready=0 during that time. A second request while busy is ignored.
- Restart/enable: restart mid-CAP_LA → cur=start, FIFO empty, refetch runs with no tick. enable=0 for 40 cycles → no note_tick, tones stable.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared types and helpers for the APU note sequencer.
//   seq_state_t : sequencer FSM states (explicit 3-bit encoding)
//   SILENT      : tone code meaning "no sound" / "no override"
//   ch_lsb()    : bit offset of a channel field in a packed tone word
//                 (channel 0 sits in the MSBs)
package apu_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_CUR = 3'd1,
        S_FETCH_LA  = 3'd2,
        S_CAP_LA    = 3'd3,
        S_PLAY      = 3'd4
    } seq_state_t;

    localparam int SILENT = 0;

    function automatic int ch_lsb(input int ch, input int num_ch, input int tone_w);
        return (num_ch - 1 - ch) * tone_w;
    endfunction

endpackage

// File: rtl/la_fifo.sv
// la_fifo: synchronous FIFO for lookahead tones.
//   clk, reset     : clock, async active-high reset
//   i_flush        : sync clear of contents and overflow flag (wins over push/pop)
//   i_push, i_data : write request; dropped when full unless a pop happens too
//   i_pop          : read request; ignored when empty
//   o_data         : head entry
//   o_valid        : FIFO non-empty
//   o_full         : FIFO full
//   o_overflow     : sticky, set when a push was dropped
module la_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_overflow
);
    localparam int AW = $clog2(DEPTH);

    generate
        if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_depth_chk
            $error("la_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_empty, w_full, w_pop, w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (i_push && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_flush && w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks pattern memory between loop bounds at the note rate,
// drives NUM_CH tone codes with per-channel one-shot overrides, and queues
// lookahead tones (channel NUM_CH-1) into a small FIFO.
//   clk, reset              : audio clock, async active-high reset
//   enable                  : run; low freezes tick counter and FSM
//   restart                 : sync pulse, back to start_addr, flush FIFO/one-shots
//   start_addr/end_addr     : inclusive loop bounds
//   la_offset               : lookahead distance in notes
//   mem_addr/mem_rdata      : pattern memory port (registered read, ch0 in MSBs)
//   os_valid/os_tones/os_len/os_ready : one-shot override handshake
//   tones, note_tick, timestamp       : player outputs
//   la_valid/la_tone/la_ready/la_overflow : lookahead FIFO consumer side
module note_sequencer
    import apu_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TONE_W   = 4,
    parameter int ADDR_W   = 10,
    parameter int CLK_HZ   = 12_288_000,
    parameter int NOTE_HZ  = 1,
    parameter int LA_DEPTH = 4,
    parameter int OS_LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
    input  logic [ADDR_W-1:0]        la_offset,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [NUM_CH*TONE_W-1:0] mem_rdata,
    input  logic                     os_valid,
    input  logic [NUM_CH*TONE_W-1:0] os_tones,
    input  logic [OS_LEN_W-1:0]      os_len,
    output logic                     os_ready,
    output logic [NUM_CH*TONE_W-1:0] tones,
    output logic                     note_tick,
    output logic [ADDR_W-1:0]        timestamp,
    output logic                     la_valid,
    output logic [TONE_W-1:0]        la_tone,
    input  logic                     la_ready,
    output logic                     la_overflow
);
    localparam int PERIOD = CLK_HZ / NOTE_HZ;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int LA_LSB = ch_lsb(NUM_CH - 1, NUM_CH, TONE_W);

    generate
        if (PERIOD < 8) begin : g_period_chk
            $error("note_sequencer: CLK_HZ/NOTE_HZ must be >= 8");
        end
    endgenerate

    seq_state_t               r_state;
    logic [CNT_W-1:0]         r_tick_cnt;
    logic                     r_init;      // cur_addr not yet loaded: treat it as start_addr
    logic                     r_rd_cur;    // mem_rdata this cycle is the current-note word
    logic [ADDR_W-1:0]        r_cur, r_mem_addr;
    logic [NUM_CH*TONE_W-1:0] r_pat, r_word;
    logic [NUM_CH-1:0]        r_os_act;
    logic [NUM_CH*TONE_W-1:0] r_os_tone;
    logic [OS_LEN_W-1:0]      r_os_rem;

    logic                     w_tick, w_push, w_os_take;
    logic [ADDR_W-1:0]        w_cur, w_next, w_la;
    logic [ADDR_W:0]          w_sum, w_len, w_sub;
    logic [NUM_CH-1:0]        w_os_nz;

    assign w_tick = enable && (r_tick_cnt == CNT_W'(PERIOD - 1));
    assign w_cur  = r_init ? start_addr : r_cur;
    assign w_next = (w_cur >= end_addr) ? start_addr : w_cur + ADDR_W'(1);

    // Lookahead wraps once by the loop length; anything still past end_addr
    // (offset >= loop length) is pulled back to start_addr to stay in the loop.
    assign w_sum = {1'b0, w_cur} + {1'b0, la_offset};
    assign w_len = {1'b0, end_addr} - {1'b0, start_addr} + (ADDR_W+1)'(1);
    assign w_sub = (w_sum > {1'b0, end_addr}) ? w_sum - w_len : w_sum;
    assign w_la  = (end_addr <= start_addr || w_sub > {1'b0, end_addr})
                   ? start_addr : w_sub[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH_CUR;
            r_init     <= 1'b1;
            r_tick_cnt <= '0;
            r_cur      <= '0;
            r_mem_addr <= '0;
            r_pat      <= '0;
        end else if (restart) begin
            r_state    <= S_FETCH_CUR;
            r_init     <= 1'b1;
            r_tick_cnt <= '0;
        end else if (enable) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_tick) r_cur <= w_next;
            case (r_state)
                S_IDLE, S_PLAY: begin
                    if (w_tick) begin
                        r_state    <= S_FETCH_CUR;
                        r_mem_addr <= w_next;
                    end
                end
                S_FETCH_CUR: begin
                    // After reset/restart the address register is stale: load it first.
                    if (r_init) begin
                        r_init     <= 1'b0;
                        r_cur      <= w_cur;
                        r_mem_addr <= w_cur;
                    end else begin
                        r_state    <= S_FETCH_LA;
                        r_mem_addr <= w_la;
                    end
                end
                S_FETCH_LA: begin
                    // After a pause here the port already returns the lookahead
                    // word, so take the current word from the side copy.
                    r_pat   <= r_rd_cur ? mem_rdata : r_word;
                    r_state <= S_CAP_LA;
                end
                S_CAP_LA: r_state <= S_PLAY;
                default:  r_state <= S_FETCH_CUR;
            endcase
        end
    end

    // Tracks the memory pipeline independent of enable so the current word
    // is never lost when the FSM pauses between address and capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cur <= 1'b0;
            r_word   <= '0;
        end else begin
            r_rd_cur <= !restart && (r_state == S_FETCH_CUR) && !r_init;
            if (r_rd_cur) r_word <= mem_rdata;
        end
    end

    assign os_ready  = (r_os_rem == '0);
    assign w_os_take = os_valid && os_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_os_act  <= '0;
            r_os_tone <= '0;
            r_os_rem  <= '0;
        end else if (restart) begin
            r_os_act <= '0;
            r_os_rem <= '0;
        end else if (w_os_take) begin
            r_os_act  <= w_os_nz;
            r_os_tone <= os_tones;
            r_os_rem  <= (os_len == '0) ? OS_LEN_W'(1) : os_len;
        end else if (w_tick && !os_ready) begin
            r_os_rem <= r_os_rem - OS_LEN_W'(1);
            if (r_os_rem == OS_LEN_W'(1)) r_os_act <= '0;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            localparam int LSB = ch_lsb(g, NUM_CH, TONE_W);
            assign w_os_nz[g] = (os_tones[LSB +: TONE_W] != TONE_W'(SILENT));
            assign tones[LSB +: TONE_W] = r_os_act[g] ? r_os_tone[LSB +: TONE_W]
                                                      : r_pat[LSB +: TONE_W];
        end
    endgenerate

    assign w_push = enable && (r_state == S_CAP_LA)
                    && (mem_rdata[LA_LSB +: TONE_W] != TONE_W'(SILENT));

    la_fifo #(
        .DEPTH (LA_DEPTH),
        .WIDTH (TONE_W)
    ) u_la_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (restart),
        .i_push     (w_push),
        .i_data     (mem_rdata[LA_LSB +: TONE_W]),
        .i_pop      (la_ready),
        .o_data     (la_tone),
        .o_valid    (la_valid),
        .o_full     (),
        .o_overflow (la_overflow)
    );

    assign mem_addr  = r_mem_addr;
    assign note_tick = w_tick;
    assign timestamp = w_cur - start_addr;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench for note_sequencer with PERIOD = 16 and a
// registered-read pattern memory holding word i = 16'h1110 + i.
module tb_note_sequencer;
    localparam int NUM_CH = 4, TONE_W = 4, ADDR_W = 10, OS_LEN_W = 4;

    logic                     clk = 1'b0;
    logic                     reset, enable, restart, os_valid, la_ready;
    logic [ADDR_W-1:0]        start_addr, end_addr, la_offset;
    logic [ADDR_W-1:0]        mem_addr, timestamp;
    logic [NUM_CH*TONE_W-1:0] mem_rdata, os_tones, tones;
    logic [OS_LEN_W-1:0]      os_len;
    logic                     os_ready, note_tick, la_valid, la_overflow;
    logic [TONE_W-1:0]        la_tone;

    logic [15:0] mem [0:1023];
    int          cyc = 0;
    int          n_vec = 0, n_err = 0;

    note_sequencer #(
        .NUM_CH(NUM_CH), .TONE_W(TONE_W), .ADDR_W(ADDR_W), .CLK_HZ(16),
        .NOTE_HZ(1), .LA_DEPTH(4), .OS_LEN_W(OS_LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .start_addr(start_addr), .end_addr(end_addr), .la_offset(la_offset),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .os_valid(os_valid),
        .os_tones(os_tones), .os_len(os_len), .os_ready(os_ready), .tones(tones),
        .note_tick(note_tick), .timestamp(timestamp), .la_valid(la_valid),
        .la_tone(la_tone), .la_ready(la_ready), .la_overflow(la_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (note_tick !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk("tick_seen", note_tick, 1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    initial begin
        int t_prev, n_tk, n_chg;
        logic [15:0] w_tones [3]  = '{16'h1113, 16'h1114, 16'h1112};
        logic [9:0]  w_ts    [3]  = '{10'd1, 10'd2, 10'd0};
        logic [3:0]  w_la2   [3]  = '{4'd4, 4'd2, 4'd3};
        logic [3:0]  w_la3   [6]  = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
        logic        w_ovf   [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  w_pop   [4]  = '{4'd3, 4'd4, 4'd5, 4'd6};

        for (int i = 0; i < 1024; i++) mem[i] = 16'h1110 + 16'(i);
        reset = 1'b1; enable = 1'b1; restart = 1'b0; os_valid = 1'b0;
        os_tones = '0; os_len = '0; la_ready = 1'b1;
        start_addr = 10'd2; end_addr = 10'd4; la_offset = 10'd1;

        // Reset state
        #12;
        chk("rst_tones", tones, 16'h0000);
        chk("rst_tick", note_tick, 0);
        chk("rst_os_ready", os_ready, 1);
        chk("rst_la_valid", la_valid, 0);
        chk("rst_ovf", la_overflow, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ts", timestamp, 0);
        #10 reset = 1'b0;
        step(1);

        // Loop wrap 2..4 with latency checks
        wait_tick();
        t_prev = cyc;
        chk("init_tones", tones, 16'h1112);
        chk("init_ts", timestamp, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_tick();
                chk($sformatf("tick_period%0d", i), cyc - t_prev, 16);
                t_prev = cyc;
            end
            step(1);
            if (i == 0) chk("lat_addr_cur", mem_addr, 3);
            step(1);
            if (i == 0) chk("lat_addr_la", mem_addr, 4);
            chk($sformatf("lat_tones_hold%0d", i), tones, (i == 0) ? 16'h1112 : w_tones[i-1]);
            step(1);
            chk($sformatf("wrap_tones%0d", i), tones, w_tones[i]);
            chk($sformatf("wrap_ts%0d", i), timestamp, w_ts[i]);
            chk($sformatf("lat_la_lo%0d", i), la_valid, 0);
            step(1);
            chk($sformatf("lat_la_hi%0d", i), la_valid, 1);
            chk($sformatf("wrap_la_tone%0d", i), la_tone, w_la2[i]);
        end

        // Lookahead 0..7, offset 3; zero nibble (word 0) never queued
        start_addr = 10'd0; end_addr = 10'd7; la_offset = 10'd3;
        do_restart();
        for (int i = 0; i < 6; i++) begin
            wait_tick();
            step(4);
            chk($sformatf("la_tones%0d", i), tones, 16'h1111 + 16'(i));
            chk($sformatf("la_valid%0d", i), la_valid, w_la3[i] != 0);
            if (w_la3[i] != 0) chk($sformatf("la_tone%0d", i), la_tone, w_la3[i]);
        end

        // Overflow: 5 non-zero pushes into a depth-4 FIFO
        la_ready = 1'b0;
        do_restart();
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            step(4);
            chk($sformatf("ovf_flag%0d", i), la_overflow, w_ovf[i]);
        end
        la_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pop_valid%0d", k), la_valid, 1);
            chk($sformatf("pop_tone%0d", k), la_tone, w_pop[k]);
            step(1);
        end
        chk("pop_empty", la_valid, 0);
        chk("ovf_sticky", la_overflow, 1);
        la_ready = 1'b0;
        do_restart();
        chk("ovf_cleared", la_overflow, 0);

        // Restart in CAP_LA: flush, cur back to start, refetch without a tick
        wait_tick();
        step(3);
        chk("cap_tones", tones, 16'h1111);
        chk("cap_la_valid", la_valid, 1);
        do_restart();
        chk("rs_ts", timestamp, 0);
        chk("rs_flushed", la_valid, 0);
        chk("rs_tones_hold", tones, 16'h1111);
        step(2);
        chk("rs_tones_hold2", tones, 16'h1111);
        step(1);
        chk("rs_refetch_tones", tones, 16'h1110);
        step(1);
        chk("rs_refetch_la", la_valid, 1);
        chk("rs_refetch_tone", la_tone, 3);

        // One-shot on ch1 for 2 notes; a second request while busy is dropped
        la_ready = 1'b1;
        do_restart();
        wait_tick();
        step(4);
        chk("os_ready_idle", os_ready, 1);
        os_valid = 1'b1; os_tones = 16'h0F00; os_len = 4'd2;
        step(1);
        os_valid = 1'b0;
        chk("os_busy", os_ready, 0);
        chk("os_apply", tones, 16'h1F11);
        os_valid = 1'b1; os_tones = 16'h000A; os_len = 4'd5;
        step(1);
        os_valid = 1'b0;
        chk("os_ignored", tones, 16'h1F11);
        wait_tick();
        step(3);
        chk("os_note2", tones, 16'h1F12);
        chk("os_busy2", os_ready, 0);
        step(1);
        wait_tick();
        chk("os_last_cycle", tones, 16'h1F12);
        step(1);
        chk("os_done_ready", os_ready, 1);
        chk("os_done_tones", tones, 16'h1112);
        step(2);
        chk("os_after", tones, 16'h1113);

        // enable low for 40 cycles in PLAY
        step(2);
        enable = 1'b0;
        n_tk = 0; n_chg = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (note_tick) n_tk++;
            if (tones !== 16'h1113) n_chg++;
        end
        chk("pause_ticks", n_tk, 0);
        chk("pause_tone_changes", n_chg, 0);
        chk("pause_ts", timestamp, 3);
        enable = 1'b1;

        // enable low while in FETCH_LA
        wait_tick();
        step(2);
        enable = 1'b0;
        step(5);
        chk("fla_addr_hold", mem_addr, 7);
        chk("fla_tones_hold", tones, 16'h1113);
        enable = 1'b1;
        step(1);
        chk("fla_resume_tones", tones, 16'h1114);

        // Async reset mid-operation
        #2 reset = 1'b1;
        #1;
        chk("arst_tones", tones, 16'h0000);
        chk("arst_os_ready", os_ready, 1);
        chk("arst_la_valid", la_valid, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_ts", timestamp, 0);
        #10 reset = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
